// File: rtl/stream_framing_guard_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_framing_guard_if
// Purpose  : Bundles the upstream (mux-side) and downstream beat streams of
//            stream_framing_guard.
//            in_*  : 512-bit beat from the mux plus ready/almost-full back.
//            out_* : framed 512-bit beat to the consumer plus ready.
//            Modport slave  : the guard's view.
//            Modport master : the environment's view (mux + consumer).
// Revision : 1.0  initial release
// ============================================================================
interface stream_framing_guard_if;
  logic [511:0] in_data;
  logic         in_valid;
  logic         in_sop;
  logic         in_eop;
  logic [5:0]   in_empty;
  logic         in_ready;
  logic         in_almost_full;

  logic [511:0] out_data;
  logic         out_valid;
  logic         out_sop;
  logic         out_eop;
  logic [5:0]   out_empty;
  logic         out_ready;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
    output in_ready, in_almost_full,
    output out_data, out_valid, out_sop, out_eop, out_empty
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
    input  in_ready, in_almost_full,
    input  out_data, out_valid, out_sop, out_eop, out_empty
  );
endinterface
`default_nettype wire

// File: rtl/stream_framing_guard.sv
`default_nettype none
// ============================================================================
// Module   : stream_framing_guard
// Purpose  : Enforces sop/eop framing on the merged 512-bit mux stream.
//            Drops beats outside a packet, force-terminates packets that are
//            interrupted by a new sop, and buffers beats in a FWFT FIFO that
//            provides registered almost-full backpressure to the mux.
// Ports    : clk, rst         single clock, async active-high reset
//            strm (slave)     in_* beat stream, in_ready, in_almost_full,
//                             out_* beat stream, out_ready
//            stat_pkt         packets written to the FIFO
//            stat_drop_beats  beats discarded
//            stat_err         framing errors
// Config   : STREAM_GUARD_STATS_EN  defined -> saturating statistics counters
//                                   undefined -> stat_* tied to 0
// Revision : 1.0  initial release
// ============================================================================
module stream_framing_guard #(
  parameter int FIFO_DEPTH = 64,
  parameter int AF_MARGIN  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_framing_guard_if.slave strm,
  output logic [31:0]          stat_pkt,
  output logic [31:0]          stat_drop_beats,
  output logic [31:0]          stat_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = 512 + 1 + 1 + 6;
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(FIFO_DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Hold register
  logic         hold_valid_q, hold_valid_d;
  logic [511:0] hold_data_q,  hold_data_d;
  logic         hold_sop_q,   hold_sop_d;
  logic         hold_eop_q,   hold_eop_d;
  logic [5:0]   hold_empty_q, hold_empty_d;

  // FIFO
  logic [BW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          af_q,     af_d;

  logic          in_ready_w;
  logic          accept;
  logic          pop;
  logic          out_valid_w;
  logic          wr_room;
  logic          flush;
  logic          load;
  logic          force_eop;
  logic          drop_evt;
  logic          err_evt;
  logic          wr_eop;
  logic [BW-1:0] wr_word;
  logic [BW-1:0] head;

  assign in_ready_w  = !rst && (!hold_valid_q || (count_q < DEPTH_LVL));
  assign accept      = strm.in_valid && in_ready_w;
  assign out_valid_w = (count_q != '0);
  assign pop         = out_valid_w && strm.out_ready;
  // A pop frees its slot in the same cycle, so a full FIFO can still take
  // the hold beat when the head is leaving.
  assign wr_room     = (count_q < DEPTH_LVL) || pop;

  // Input framing FSM: decides whether an accepted beat is kept or dropped
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    force_eop = 1'b0;
    drop_evt  = 1'b0;
    err_evt   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE, ST_DROP: begin
          if (strm.in_sop) begin
            load    = 1'b1;
            state_d = strm.in_eop ? ST_IDLE : ST_IN_PKT;
          end else begin
            drop_evt = 1'b1;
            // Only the first headless beat is an error; the rest of the
            // fragment is just counted as dropped.
            err_evt  = (state_q == ST_IDLE);
            state_d  = strm.in_eop ? ST_IDLE : ST_DROP;
          end
        end
        ST_IN_PKT: begin
          load = 1'b1;
          if (strm.in_sop) begin
            // New sop mid-packet: close the held beat as the packet end.
            force_eop = 1'b1;
            err_evt   = 1'b1;
          end
          state_d = strm.in_eop ? ST_IDLE : ST_IN_PKT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Hold beat moves to the FIFO once its successor is known (or it is the
  // packet end). An accepted beat always finds room because in_ready already
  // requires a free slot whenever hold is occupied.
  assign flush   = hold_valid_q && wr_room && (hold_eop_q || accept);
  assign wr_eop  = hold_eop_q || force_eop;
  assign wr_word = {hold_data_q, hold_sop_q, wr_eop, hold_empty_q};

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_sop_d   = hold_sop_q;
    hold_eop_d   = hold_eop_q;
    hold_empty_d = hold_empty_q;
    if (load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = strm.in_data;
      hold_sop_d   = strm.in_sop;
      hold_eop_d   = strm.in_eop;
      hold_empty_d = strm.in_eop ? strm.in_empty : 6'd0;
    end else if (flush) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(flush);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(flush) - (AW+1)'(pop);
    af_d     = ((count_q + (AW+1)'(hold_valid_q)) >= AF_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_sop_q   <= 1'b0;
      hold_eop_q   <= 1'b0;
      hold_empty_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      af_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_sop_q   <= hold_sop_d;
      hold_eop_q   <= hold_eop_d;
      hold_empty_q <= hold_empty_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      af_q         <= af_d;
    end
  end

  // Storage is not reset; the output is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (flush) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign strm.in_ready       = in_ready_w;
  assign strm.in_almost_full = af_q;
  assign strm.out_valid      = out_valid_w;
  assign strm.out_data       = out_valid_w ? head[BW-1:8] : '0;
  assign strm.out_sop        = out_valid_w & head[7];
  assign strm.out_eop        = out_valid_w & head[6];
  assign strm.out_empty      = out_valid_w ? head[5:0] : 6'd0;

`ifdef STREAM_GUARD_STATS_EN
  logic [31:0] pkt_q;
  logic [31:0] drop_q;
  logic [31:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      if (flush && wr_eop && (pkt_q != 32'hFFFF_FFFF)) begin
        pkt_q <= pkt_q + 32'd1;
      end
      if (drop_evt && (drop_q != 32'hFFFF_FFFF)) begin
        drop_q <= drop_q + 32'd1;
      end
      if (err_evt && (err_q != 32'hFFFF_FFFF)) begin
        err_q <= err_q + 32'd1;
      end
    end
  end

  assign stat_pkt        = pkt_q;
  assign stat_drop_beats = drop_q;
  assign stat_err        = err_q;
`else
  logic unused_stat_events;
  assign unused_stat_events = &{1'b0, drop_evt, err_evt};

  assign stat_pkt        = 32'd0;
  assign stat_drop_beats = 32'd0;
  assign stat_err        = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/stream_framing_guard.md
# stream_framing_guard

Sits directly downstream of the three-way packet stream mux and drives that mux's `out_ready` and `out_almost_full` inputs. It enforces sop/eop framing on the merged 512-bit stream before it leaves the mux domain:
- drops beats that arrive outside a packet;
- force-terminates packets that are interrupted by a new sop;
- buffers beats in an internal FIFO that supplies the early almost-full backpressure the mux expects.

## Interface
Parameters:
- `FIFO_DEPTH`, 64: beats of buffering; power of two, minimum 8.
- `AF_MARGIN`, 8: `in_almost_full` asserts when occupancy ≥ `FIFO_DEPTH - AF_MARGIN`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_data`  in  512: beat from the mux.
- `in_valid`  in  1: beat valid.
- `in_sop`  in  1: start of packet.
- `in_eop`  in  1: end of packet.
- `in_empty`  in  6: empty bytes, meaningful on eop only.
- `in_ready`  out  1: beat accepted when `in_valid && in_ready`.
- `in_almost_full`  out  1: registered early backpressure to the mux.
- `out_data`  out  512: output beat.
- `out_valid`  out  1: output beat valid.
- `out_sop`  out  1: start of packet.
- `out_eop`  out  1: end of packet.
- `out_empty`  out  6: empty bytes.
- `out_ready`  in  1: downstream ready.
- `stat_pkt`  out  32: count of packets written to the FIFO.
- `stat_drop_beats`  out  32: count of beats discarded.
- `stat_err`  out  32: count of framing errors.

## Operation
- Input FSM has three states, IDLE / IN_PKT / DROP. It acts only on accepted beats.
  - IDLE, sop=1: load beat into the hold register. Next state is IDLE if eop=1, else IN_PKT.
  - IDLE, sop=0: discard the beat and add 1 to `stat_drop_beats`.
    - If eop=0: go to DROP and add 1 to `stat_err`.
    - If eop=1: stay in IDLE and add 1 to `stat_err`.
  - IN_PKT, sop=0: load beat into hold; on eop go to IDLE.
  - IN_PKT, sop=1 (interrupted packet):
    - The current hold beat is flushed with eop forced to 1 and empty forced to 0.
    - The new beat is loaded into hold and starts a new packet.
    - Add 1 to `stat_err`.
    - Next state is IDLE if the new beat has eop=1, else IN_PKT.
  - DROP: discard every beat and add 1 to `stat_drop_beats` per beat.
    - An eop beat returns the FSM to IDLE.
    - A sop beat is treated as IDLE with sop=1: it is kept and starts a packet.
- Hold register: one beat of data, sop, eop and empty.
  - The hold beat is flushed (written to the FIFO) when hold is valid, the FIFO is not full, and either hold.eop=1 or a new beat is accepted in the same cycle.
  - A flush and a new load in the same cycle are one FIFO write plus one hold load.
  - Non-eop beats force empty to 0 on entry to hold.
- `in_ready` = !rst && (!hold_valid || fifo_count < FIFO_DEPTH).
- `stat_pkt` increments on every FIFO write that carries eop=1, including forced eops.
- FIFO is first-word-fall-through.
  - `out_valid` = (fifo_count != 0); `out_*` show the head beat.
  - The head is popped on `out_valid && out_ready`.
- A simultaneous FIFO write and pop leaves the count unchanged and is legal when the FIFO is full, because the pop frees the slot in the same cycle.
- The FIFO read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. `fifo_count` is one bit wider.
- Statistics counters saturate at 0xFFFF_FFFF.

## Timing
- Reset: all outputs are 0 while `rst` is high.
  - This covers `in_ready` and `in_almost_full` as well as the output beat and statistics.
  - FSM returns to IDLE; hold and FIFO are emptied; counters clear.
- Reset mid-packet discards all partial data. No eop is emitted for the partial packet.
- Latency: an eop beat accepted at edge t is written to the FIFO at edge t+1 and appears on `out_*` with `out_valid`=1 after edge t+1.
- Non-eop beats stay in hold until the next beat of their packet is accepted.
- `in_almost_full` is registered from (fifo_count + hold_valid) ≥ FIFO_DEPTH−AF_MARGIN, so it lags occupancy by one cycle.
- Throughput: one beat per cycle in and out at steady state.

## Configuration
- `STREAM_GUARD_STATS_EN` defined: the three saturating 32-bit counters are implemented.
- `STREAM_GUARD_STATS_EN` undefined: the counters are removed. `stat_*` are tied to 0, and framing behaviour is identical.

## Test plan
- Clean traffic: a 3-beat packet (sop, -, eop with empty=5) then a 1-beat packet (sop+eop, empty=0), `out_ready`=1. Required:
  - Output is identical: 4 beats, empties 0,0,5,0.
  - `stat_pkt`=2; `stat_err`=0; `stat_drop_beats`=0.
- Stray beats: in IDLE, feed a 2-beat headless fragment (no sop, then eop), then a valid 1-beat packet. Required:
  - The fragment never appears on the output.
  - `stat_drop_beats`=2, `stat_err`=1, `stat_pkt`=1.
- Interrupted packet: sop beat A, then sop+eop beat B. Required:
  - Output is A with eop=1 and empty=0, then B.
  - `stat_err`=1, `stat_pkt`=2.
- Backpressure (FIFO_DEPTH=64, AF_MARGIN=8): hold `out_ready`=0 and stream beats. Required:
  - `in_almost_full` rises one cycle after occupancy reaches 56.
  - `in_ready` falls when the FIFO holds 64 beats and hold is valid.
  - Releasing `out_ready` delivers all 65 beats in order with no loss.
- Full FIFO with concurrent pop: at full FIFO, hold valid with eop, `out_ready`=1. Required: the hold flushes in the same cycle as the pop and the count stays at 64.
- Reset mid-packet: assert `rst` after the sop beat of a 4-beat packet. Required:
  - All outputs are 0 during reset.
  - After release, the remaining non-sop beats are dropped in IDLE (sop=0, eop=0 → DROP), and `stat_err`=1 is counted post-reset.
